// File: rtl/btb_lru_predictor.sv
// rtl/btb_lru_predictor.sv - fully-associative BTB with saturating direction counters and true-LRU replacement
module btb_lru_predictor #(
    parameter int ENTRIES = 8,
    parameter int AW      = 32,
    parameter int CTR_W   = 2,
    parameter int PC_STEP = 1,
    parameter int STAT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [AW-1:0]              lk_pc,
    output logic                       lk_hit,
    output logic [$clog2(ENTRIES)-1:0] lk_idx,
    output logic                       lk_taken,
    output logic [AW-1:0]              pc_pred,
    input  logic                       upd_valid,
    input  logic [AW-1:0]              upd_pc,
    input  logic                       upd_taken,
    input  logic [AW-1:0]              upd_target,
    input  logic                       upd_mispred,
    input  logic                       clr_stats,
    output logic [STAT_W-1:0]          stat_updates,
    output logic [STAT_W-1:0]          stat_mispred
);

    localparam int IW = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [IW-1:0]    AGE_LRU  = IW'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid;
    logic [CTR_W-1:0]   ctr    [ENTRIES];
    logic [AW-1:0]      tag    [ENTRIES];
    logic [AW-1:0]      target [ENTRIES];
    logic [IW-1:0]      age    [ENTRIES];

    logic          upd_hit;
    logic [IW-1:0] upd_idx;
    logic          have_free;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] lru_idx;
    logic [IW-1:0] prom_idx;
    logic [IW-1:0] prom_age;
    logic          accept;
    logic          promote;

    // Downward scans so the lowest matching index is the one left standing.
    always_comb begin
        lk_hit    = 1'b0;
        lk_idx    = '0;
        upd_hit   = 1'b0;
        upd_idx   = '0;
        have_free = 1'b0;
        free_idx  = '0;
        lru_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == lk_pc) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
            if (valid[i] && tag[i] == upd_pc) begin
                upd_hit = 1'b1;
                upd_idx = IW'(i);
            end
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = IW'(i);
            end
            if (age[i] == AGE_LRU) begin
                lru_idx = IW'(i);
            end
        end
    end

    assign lk_taken = lk_hit & ctr[lk_idx][CTR_W-1];
    assign pc_pred  = lk_taken ? target[lk_idx] : lk_pc + AW'(PC_STEP);

    assign accept   = upd_valid & ~flush;
    assign promote  = accept & (upd_hit | upd_taken);
    assign prom_idx = upd_hit ? upd_idx : (have_free ? free_idx : lru_idx);
    assign prom_age = age[prom_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i]    <= CTR_INIT;
                tag[i]    <= '0;
                target[i] <= '0;
                age[i]    <= IW'(i);
            end
        end else if (flush) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                age[i] <= IW'(i);
            end
        end else if (accept) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr[upd_idx] != CTR_MAX) ctr[upd_idx] <= ctr[upd_idx] + CTR_W'(1);
                    target[upd_idx] <= upd_target;
                end else if (ctr[upd_idx] != '0) begin
                    ctr[upd_idx] <= ctr[upd_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid[prom_idx]  <= 1'b1;
                tag[prom_idx]    <= upd_pc;
                target[prom_idx] <= upd_target;
                ctr[prom_idx]    <= CTR_INIT;
            end
            // Younger entries age by one so ages stay a permutation.
            if (promote) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (IW'(i) == prom_idx) age[i] <= '0;
                    else if (age[i] < prom_age) age[i] <= age[i] + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (clr_stats) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (accept) begin
            if (stat_updates != '1) stat_updates <= stat_updates + STAT_W'(1);
            if (upd_mispred && stat_mispred != '1) stat_mispred <= stat_mispred + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_lru_predictor.sv
// tb/tb_btb_lru_predictor.sv - directed table-driven bench for btb_lru_predictor
module tb_btb_lru_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        lk_hit;
    logic [2:0]  lk_idx;
    logic        lk_taken;
    logic [31:0] pc_pred;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispred = 1'b0;
    logic        clr_stats = 1'b0;
    logic [4:0]  stat_updates;
    logic [4:0]  stat_mispred;

    int checks = 0;
    int errors = 0;

    btb_lru_predictor #(.ENTRIES(8), .AW(32), .CTR_W(2), .PC_STEP(1), .STAT_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_idx(lk_idx), .lk_taken(lk_taken), .pc_pred(pc_pred),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispred(upd_mispred), .clr_stats(clr_stats),
        .stat_updates(stat_updates), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        fl;
        logic [31:0] cpc;
        logic        e_hit;
        logic [2:0]  e_idx;
        logic        e_tk;
        logic [31:0] e_pred;
        logic [4:0]  e_upd;
        logic [4:0]  e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt, logic um,
                                logic fl, logic [31:0] cpc, logic e_hit, logic [2:0] e_idx,
                                logic e_tk, logic [31:0] e_pred, logic [4:0] e_upd, logic [4:0] e_mis);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um; v.fl = fl; v.cpc = cpc;
        v.e_hit = e_hit; v.e_idx = e_idx; v.e_tk = e_tk; v.e_pred = e_pred;
        v.e_upd = e_upd; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, vec_t v);
        chk({nm, " lk_hit"}, 32'(lk_hit), 32'(v.e_hit));
        chk({nm, " lk_idx"}, 32'(lk_idx), 32'(v.e_idx));
        chk({nm, " lk_taken"}, 32'(lk_taken), 32'(v.e_tk));
        chk({nm, " pc_pred"}, pc_pred, v.e_pred);
        chk({nm, " stat_updates"}, 32'(stat_updates), 32'(v.e_upd));
        chk({nm, " stat_mispred"}, 32'(stat_mispred), 32'(v.e_mis));
    endtask

    task automatic apply(string nm, vec_t v);
        @(negedge clk);
        upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
        upd_mispred = v.um; flush = v.fl;
        @(posedge clk);
        #1;
        upd_valid = 1'b0; flush = 1'b0; clr_stats = 1'b0; upd_mispred = 1'b0;
        lk_pc = v.cpc;
        #1;
        chk_all(nm, v);
    endtask

    initial begin
        // Training on 0x40, an empty-table flush, then LRU fill/evict, then flush racing an update.
        vecs.push_back(mk(1, 32'h40, 1, 32'h80, 1, 0, 32'h40, 1, 0, 1, 32'h80, 1, 1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  1, 0, 32'h40, 1, 0, 0, 32'h41, 2, 2));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h40, 1, 0, 0, 32'h41, 3, 2));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h40, 1, 0, 0, 32'h41, 4, 2));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h40, 0, 0, 0, 32'h41, 4, 2));
        vecs.push_back(mk(1, 32'h10, 0, 32'h0,  0, 0, 32'h10, 0, 0, 0, 32'h11, 5, 2));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 32'h100 + i, 1, 32'h500 + i, 0, 0, 32'h100 + i,
                              1, 3'(i), 1, 32'h500 + i, 5'(6 + i), 2));
        vecs.push_back(mk(1, 32'h100, 1, 32'h5A0, 0, 0, 32'h100, 1, 0, 1, 32'h5A0, 14, 2));
        vecs.push_back(mk(1, 32'h200, 1, 32'h600, 0, 0, 32'h200, 1, 1, 1, 32'h600, 15, 2));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h100, 1, 0, 1, 32'h5A0, 15, 2));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h101, 0, 0, 0, 32'h102, 15, 2));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h107, 1, 7, 1, 32'h507, 15, 2));
        vecs.push_back(mk(1, 32'h300, 1, 32'h700, 1, 1, 32'h100, 0, 0, 0, 32'h101, 15, 2));

        lk_pc = 32'h40;
        #23;
        rst = 1'b0;
        #1;
        chk_all("reset", mk(0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 32'h41, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Two taken updates on consecutive edges for a new PC must share one entry.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h700;
        @(posedge clk);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        lk_pc = 32'h300;
        #1;
        chk_all("b2b", mk(0, 0, 0, 0, 0, 0, 32'h300, 1, 0, 1, 32'h700, 17, 2));
        apply("b2b_next", mk(1, 32'h301, 1, 32'h800, 0, 0, 32'h301, 1, 1, 1, 32'h800, 18, 2));
        apply("b2b_nt1",  mk(1, 32'h300, 0, 32'h0,   0, 0, 32'h300, 1, 0, 1, 32'h700, 19, 2));
        apply("b2b_nt2",  mk(1, 32'h300, 0, 32'h0,   0, 0, 32'h300, 1, 0, 0, 32'h301, 20, 2));

        for (int k = 0; k < 20; k++)
            apply($sformatf("sat%0d", k), mk(1, 32'h10, 0, 32'h0, 1, 0, 32'h10, 0, 0, 0, 32'h11,
                                             5'((21 + k > 31) ? 31 : 21 + k), 5'(3 + k)));

        // clr_stats wins over a same-cycle update.
        @(negedge clk);
        clr_stats = 1'b1; upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0; upd_mispred = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
        #1;
        chk("clr stat_updates", 32'(stat_updates), 32'd0);
        chk("clr stat_mispred", 32'(stat_mispred), 32'd0);
        apply("after_clr", mk(1, 32'h10, 0, 32'h0, 0, 0, 32'h300, 1, 0, 0, 32'h301, 1, 0));

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", mk(0, 0, 0, 0, 0, 0, 32'h300, 0, 0, 0, 32'h301, 0, 0));
        #10;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
